// File: rtl/keypad_arbiter.sv
// Two-keypad arbiter for the security core's single command/digit entry port.
// Grants one keypad a whole code-entry sequence, round-robin, and flushes abandoned entries.
module keypad_arbiter #(
  parameter int         DIGITS_PER_CODE = 3,
  parameter int         TIMEOUT         = 255,
  parameter logic [3:0] FILL_DIGIT      = 4'hF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] kp0_command,
  input  logic [3:0] kp0_digit,
  input  logic       kp0_input_digit,
  input  logic [1:0] kp1_command,
  input  logic [3:0] kp1_digit,
  input  logic       kp1_input_digit,
  output logic       kp0_grant,
  output logic       kp1_grant,
  output logic       kp0_pending,
  output logic       kp1_pending,
  output logic [1:0] command,
  output logic [3:0] digit,
  output logic       input_digit,
  output logic       flushing
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1, FLUSH} state_t;

  localparam logic [2:0]  LAST_COUNT  = 3'(DIGITS_PER_CODE);
  localparam logic [15:0] TIMER_LIMIT = 16'(TIMEOUT);

  state_t      state;
  logic        owner;
  logic        last_owner;
  logic [1:0]  pend;
  logic [1:0]  cmd [2];
  logic [2:0]  count;
  logic [15:0] timer;

  logic [1:0]  kp_command [2];
  logic [3:0]  kp_digit [2];
  logic [1:0]  kp_strobe;
  logic [1:0]  capture;
  logic        owned;
  logic        win;
  logic [2:0]  count_inc;
  logic [15:0] timer_inc;

  assign kp_command[0] = kp0_command;
  assign kp_command[1] = kp1_command;
  assign kp_digit[0]   = kp0_digit;
  assign kp_digit[1]   = kp1_digit;
  assign kp_strobe     = {kp1_input_digit, kp0_input_digit};

  assign owned = (state != IDLE);

  // The keypad holding the port (including during its flush) cannot queue a new request.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_capture
      localparam logic SELF = 1'(gi);
      assign capture[gi] = (kp_command[gi] == 2'd1 || kp_command[gi] == 2'd2) &&
                           !(owned && owner == SELF);
    end
  endgenerate

  assign win       = (pend == 2'b11) ? ~last_owner : pend[1];
  assign count_inc = count + 3'd1;
  assign timer_inc = (timer == 16'hFFFF) ? timer : timer + 16'd1;

  assign kp0_pending = pend[0];
  assign kp1_pending = pend[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      owner       <= 1'b0;
      last_owner  <= 1'b1;
      pend        <= 2'b00;
      cmd[0]      <= 2'd0;
      cmd[1]      <= 2'd0;
      count       <= 3'd0;
      timer       <= 16'd0;
      kp0_grant   <= 1'b0;
      kp1_grant   <= 1'b0;
      command     <= 2'd0;
      digit       <= 4'd0;
      input_digit <= 1'b0;
      flushing    <= 1'b0;
    end else begin
      command     <= 2'd0;
      input_digit <= 1'b0;

      for (int i = 0; i < 2; i++) begin
        if (capture[i]) begin
          pend[i] <= 1'b1;
          cmd[i]  <= kp_command[i];
        end
      end

      case (state)
        IDLE: begin
          // Granting clears the winner's pend even if it re-requests on this same edge.
          if (pend != 2'b00) begin
            state      <= win ? OWN1 : OWN0;
            owner      <= win;
            last_owner <= win;
            pend[win]  <= 1'b0;
            command    <= cmd[win];
            kp0_grant  <= ~win;
            kp1_grant  <= win;
            count      <= 3'd0;
            timer      <= 16'd0;
          end
        end
        OWN0, OWN1: begin
          if (kp_strobe[owner]) begin
            input_digit <= 1'b1;
            digit       <= kp_digit[owner];
            count       <= count_inc;
            timer       <= 16'd0;
            if (count_inc == LAST_COUNT) begin
              state     <= IDLE;
              kp0_grant <= 1'b0;
              kp1_grant <= 1'b0;
            end
          end else begin
            timer <= timer_inc;
            if (timer_inc == TIMER_LIMIT) begin
              state    <= FLUSH;
              flushing <= 1'b1;
            end
          end
        end
        FLUSH: begin
          input_digit <= 1'b1;
          digit       <= FILL_DIGIT;
          count       <= count_inc;
          if (count_inc == LAST_COUNT) begin
            state     <= IDLE;
            kp0_grant <= 1'b0;
            kp1_grant <= 1'b0;
            flushing  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
